// File: rtl/imem_axil_rd_slave_pkg.sv
// Shared definitions for the instruction-memory AXI4-Lite read responder.
// The fetch unit reuses the response codes.
package imem_axil_rd_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // True when a byte address falls inside [base, base + depth*4).
  function automatic logic addr_in_map(input logic [31:0] addr, input logic [31:0] base,
                                       input int unsigned depth);
    logic [31:0] offset;
    offset = addr - base;
    return (addr >= base) && (offset < 32'(depth * 4));
  endfunction

endpackage

// File: rtl/imem_axil_rd_slave_if.sv
// AXI4-Lite read-channel bundle (AR + R) between a fetch master and the memory slave.
interface imem_axil_rd_slave_if;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [1:0]  rresp;
  logic [31:0] rdata;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rresp, rdata
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rresp, rdata
  );

endinterface

// File: rtl/imem_axil_rd_slave_imem_array.sv
// Word storage: synchronous write, combinational read that the caller samples at the AR
// handshake, so a same-edge write is not visible to that read.
module imem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [31:0]      i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/imem_axil_rd_slave.sv
// AXI4-Lite read-only instruction memory: one outstanding read, fixed response latency,
// backdoor preload port.
module imem_axil_rd_slave
  import imem_axil_rd_slave_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE    = 32'h8000_0000,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  imem_axil_rd_slave_if.slave        io_slave,
  input  logic                       load_en,
  input  logic [31:0]                load_addr,
  input  logic [31:0]                load_data
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [3:0]  LAT_INIT = 4'(READ_LATENCY - 1);

  state_e      r_state;
  logic        r_arready;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;
  logic [3:0]  r_cnt;

  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_ld_idx;
  logic             w_ld_we;
  logic [1:0]       w_rd_resp;
  logic [31:0]      w_arr_rdata;

  assign w_rd_idx = IDX_W'((io_slave.araddr - ADDR_BASE) >> 2);
  assign w_ld_idx = IDX_W'((load_addr - ADDR_BASE) >> 2);
  assign w_ld_we  = load_en && (load_addr[1:0] == 2'b00) &&
                    addr_in_map(load_addr, ADDR_BASE, DEPTH);

  // Misalignment outranks the range check.
  always_comb begin
    w_rd_resp = RESP_OKAY;
    if (io_slave.araddr[1:0] != 2'b00) begin
      w_rd_resp = RESP_SLVERR;
    end else if (!addr_in_map(io_slave.araddr, ADDR_BASE, DEPTH)) begin
      w_rd_resp = RESP_DECERR;
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_imem_array (
    .i_clock (clock),
    .i_we    (w_ld_we),
    .i_widx  (w_ld_idx),
    .i_wdata (load_data),
    .i_ridx  (w_rd_idx),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_cnt     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (io_slave.arvalid && r_arready) begin
            r_arready <= 1'b0;
            r_rresp   <= w_rd_resp;
            r_rdata   <= (w_rd_resp == RESP_OKAY) ? w_arr_rdata : '0;
            r_cnt     <= LAT_INIT;
            r_state   <= StWait;
          end else begin
            r_arready <= 1'b1;
          end
        end
        StWait: begin
          if (r_cnt == 4'd0) begin
            r_rvalid <= 1'b1;
            r_state  <= StResp;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StResp: begin
          if (io_slave.rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_slave.arready = r_arready;
  assign io_slave.rvalid  = r_rvalid;
  assign io_slave.rresp   = r_rresp;
  assign io_slave.rdata   = r_rdata;

endmodule

// File: tb/tb_imem_axil_rd_slave.sv
// Scoreboard bench: stimulus queues expected responses, a negedge monitor checks them.
module tb_imem_axil_rd_slave;

  logic        clk;
  logic        rst_n;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  imem_axil_rd_slave_if if0 ();
  imem_axil_rd_slave_if if1 ();

  imem_axil_rd_slave #(.READ_LATENCY(2)) u_dut0 (
    .clock     (clk),
    .reset     (rst_n),
    .io_slave  (if0),
    .load_en   (ld_en),
    .load_addr (ld_addr),
    .load_data (ld_data)
  );

  imem_axil_rd_slave #(.READ_LATENCY(5)) u_dut1 (
    .clock     (clk),
    .reset     (rst_n),
    .io_slave  (if1),
    .load_en   (ld_en),
    .load_addr (ld_addr),
    .load_data (ld_data)
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;
  int   n[2], hs[2];
  bit   busy[2], prv[2], ret[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event missing or unexpected at %0t", nm, $time);
  endfunction

  task automatic mon_step(input int i, input logic arv, input logic arr, input logic rv,
                          input logic rr, input logic [1:0] rs, input logic [31:0] rd);
    exp_t e;
    bit   have;
    n[i]++;
    have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (i == 0) ? q0[0] : q1[0];
    if (busy[i]) chk("arready_low_busy", 32'(arr), 32'd0);
    if (ret[i]) begin
      chk("arready_return", 32'(arr), 32'd1);
      ret[i] = 1'b0;
    end
    if (rv && !have) begin
      fail_now("unexpected_rvalid");
    end else if (rv) begin
      if (!prv[i]) chk("latency", 32'(n[i] - hs[i] - 1), 32'(e.lat));
      chk("rdata", rd, e.d);
      chk("rresp", 32'(rs), 32'(e.r));
      if (rr) begin
        if (i == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
        busy[i] = 1'b0;
        ret[i]  = 1'b1;
      end
    end
    if (arv && arr) begin
      hs[i]   = n[i];
      busy[i] = 1'b1;
    end
    prv[i] = rv;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        busy[i] = 1'b0;
        prv[i]  = 1'b0;
        ret[i]  = 1'b0;
      end
    end else begin
      mon_step(0, if0.arvalid, if0.arready, if0.rvalid, if0.rready, if0.rresp, if0.rdata);
      mon_step(1, if1.arvalid, if1.arready, if1.rvalid, if1.rready, if1.rresp, if1.rdata);
    end
  end

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic wait_arready0();
    for (int k = 0; k < 50 && !if0.arready; k++) begin @(posedge clk); #1; end
    if (!if0.arready) fail_now("timeout_arready");
  endtask

  task automatic wait_rvalid0();
    for (int k = 0; k < 50 && !if0.rvalid; k++) begin @(posedge clk); #1; end
    if (!if0.rvalid) fail_now("timeout_rvalid");
  endtask

  task automatic wait_q0_empty();
    for (int k = 0; k < 50 && q0.size() != 0; k++) begin @(posedge clk); #1; end
    if (q0.size() != 0) fail_now("timeout_response");
  endtask

  // Optional load to the same word either on the handshake cycle or during the R stall.
  task automatic read0(input logic [31:0] addr, input logic [31:0] ed, input logic [1:0] er,
                       input int stall, input bit ld_same, input bit ld_mid,
                       input logic [31:0] ldd);
    q0.push_back('{d: ed, r: er, lat: 2});
    if0.araddr  = addr;
    if0.arvalid = 1'b1;
    if0.rready  = (stall == 0);
    wait_arready0();
    if (ld_same) begin ld_en = 1'b1; ld_addr = addr; ld_data = ldd; end
    @(posedge clk); #1;
    if0.arvalid = 1'b0;
    ld_en       = 1'b0;
    if (stall > 0) begin
      wait_rvalid0();
      if0.arvalid = 1'b1;
      if0.araddr  = 32'h8000_0000;
      if (ld_mid) begin ld_en = 1'b1; ld_addr = addr; ld_data = ldd; end
      repeat (stall) begin @(posedge clk); #1; ld_en = 1'b0; end
      if0.arvalid = 1'b0;
      if0.rready  = 1'b1;
    end
    wait_q0_empty();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    if0.arvalid = 1'b0; if0.araddr = '0; if0.rready = 1'b1;
    if1.arvalid = 1'b0; if1.araddr = '0; if1.rready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", 32'(if0.arready), 32'd0);
    chk("rst_rvalid", 32'(if0.rvalid), 32'd0);
    chk("rst_rresp", 32'(if0.rresp), 32'd0);
    chk("rst_rdata", if0.rdata, 32'd0);
    rst_n = 1'b1;
    #1 chk("arready_before_edge", 32'(if0.arready), 32'd0);
    @(posedge clk); #1;
    chk("arready_after_release", 32'(if0.arready), 32'd1);

    load(32'h8000_0000, 32'h0000_0413);
    load(32'h8000_0004, 32'hDEAD_BEEF);
    load(32'h8000_0008, 32'h1111_1111);
    load(32'h8000_0FFC, 32'hCAFE_F00D);
    load(32'h8000_0001, 32'hBAD0_0001);
    load(32'h8000_1000, 32'hBAD0_1000);
    load(32'h7FFF_FFFC, 32'hBAD0_FFFC);

    // Latency-5 instance.
    q1.push_back('{d: 32'hDEAD_BEEF, r: 2'b00, lat: 5});
    if1.araddr = 32'h8000_0004; if1.arvalid = 1'b1;
    @(posedge clk); #1;
    if1.arvalid = 1'b0;
    for (int k = 0; k < 50 && q1.size() != 0; k++) begin @(posedge clk); #1; end
    if (q1.size() != 0) fail_now("timeout_lat5");

    read0(32'h8000_0000, 32'h0000_0413, 2'b00, 0, 1'b0, 1'b0, '0);
    read0(32'h8000_0004, 32'hDEAD_BEEF, 2'b00, 4, 1'b0, 1'b0, '0);
    read0(32'h8000_1000, 32'h0,         2'b11, 0, 1'b0, 1'b0, '0);
    read0(32'h8000_0002, 32'h0,         2'b10, 0, 1'b0, 1'b0, '0);
    read0(32'h7FFF_FFFC, 32'h0,         2'b11, 0, 1'b0, 1'b0, '0);
    read0(32'h8000_0FFC, 32'hCAFE_F00D, 2'b00, 0, 1'b0, 1'b0, '0);
    read0(32'h8000_1002, 32'h0,         2'b10, 0, 1'b0, 1'b0, '0);
    read0(32'h8000_0008, 32'h1111_1111, 2'b00, 0, 1'b1, 1'b0, 32'hA5A5_A5A5);
    read0(32'h8000_0008, 32'hA5A5_A5A5, 2'b00, 0, 1'b0, 1'b0, '0);
    read0(32'h8000_0004, 32'hDEAD_BEEF, 2'b00, 2, 1'b0, 1'b1, 32'h1234_5678);
    read0(32'h8000_0004, 32'h1234_5678, 2'b00, 0, 1'b0, 1'b0, '0);
    read0(32'h8000_0000, 32'h0000_0413, 2'b00, 0, 1'b0, 1'b0, '0);

    // Reset while waiting: nothing may come back.
    if0.araddr = 32'h8000_0000; if0.arvalid = 1'b1; if0.rready = 1'b1;
    wait_arready0();
    @(posedge clk); #1;
    if0.arvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_wait_rvalid", 32'(if0.rvalid), 32'd0);
    chk("abort_wait_arready", 32'(if0.arready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("abort_arready_pre_edge", 32'(if0.arready), 32'd0);
    @(posedge clk); #1;
    chk("abort_arready_post_edge", 32'(if0.arready), 32'd1);

    // Reset while presenting a response: rvalid must drop without waiting for a clock.
    q0.push_back('{d: 32'h0000_0413, r: 2'b00, lat: 2});
    if0.araddr = 32'h8000_0000; if0.arvalid = 1'b1; if0.rready = 1'b0;
    wait_arready0();
    @(posedge clk); #1;
    if0.arvalid = 1'b0;
    wait_rvalid0();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_resp_rvalid", 32'(if0.rvalid), 32'd0);
    q0.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    if0.rready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end

    read0(32'h8000_0000, 32'h0000_0413, 2'b00, 0, 1'b0, 1'b0, '0);
    read0(32'h8000_0FFC, 32'hCAFE_F00D, 2'b00, 1, 1'b0, 1'b0, '0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
